// File: rtl/mdu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg : shared types and constants for the multiply/divide sequencer.
//   mdu_op_t    : operation code as presented on Op.
//   mdu_state_t : sequencer FSM state encoding.
//   ALU_ADD/SUB : ALUControl codes understood by the execute-stage ALU.
//   op_is_div   : true for the divide class (DIVU/REMU).
// ---------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Op[1] separates the multiply class from the divide class.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// ---------------------------------------------------------------------------
// mdu_sequencer_if : request/result and shared-ALU signals between the
// execute stage (master) and the multiply/divide sequencer (slave).
//   Start/Op/OpA/OpB/Flush : request side, driven by execute.
//   Busy/Done/Result       : status and result, driven by the sequencer.
//   ALUReq/ALUControl/ALUSrcA/ALUSrcB : sequencer's claim on the shared ALU.
//   ALUResult              : combinational ALU output returned by execute.
// ---------------------------------------------------------------------------
interface mdu_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
);
  logic                     Start;
  logic [1:0]               Op;
  logic [DATA_WIDTH-1:0]    OpA;
  logic [DATA_WIDTH-1:0]    OpB;
  logic                     Flush;
  logic                     Busy;
  logic                     Done;
  logic [DATA_WIDTH-1:0]    Result;
  logic                     ALUReq;
  logic [CONTROL_WIDTH-1:0] ALUControl;
  logic [DATA_WIDTH-1:0]    ALUSrcA;
  logic [DATA_WIDTH-1:0]    ALUSrcB;
  logic [DATA_WIDTH-1:0]    ALUResult;

  modport master (
    output Start, Op, OpA, OpB, Flush, ALUResult,
    input  Busy, Done, Result, ALUReq, ALUControl, ALUSrcA, ALUSrcB
  );

  modport slave (
    input  Start, Op, OpA, OpB, Flush, ALUResult,
    output Busy, Done, Result, ALUReq, ALUControl, ALUSrcA, ALUSrcB
  );
endinterface

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step : one combinational iteration of shift-add multiply or restoring
// divide, using the shared ALU for the add/subtract.
//   is_div     : 1 = divide class, 0 = multiply class.
//   hi / lo    : {Hi,Lo} product for multiply, {R,Q} for divide.
//   opnd       : multiplicand A (multiply) or divisor B (divide).
//   alu_result : ALU output for the operands presented on alu_src_a/b.
//   hi_next / lo_next     : register values after this iteration.
//   alu_src_a / alu_src_b : operands to present to the ALU.
// ---------------------------------------------------------------------------
module mdu_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] opnd,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] hi_next,
  output logic [DATA_WIDTH-1:0] lo_next,
  output logic [DATA_WIDTH-1:0] alu_src_a,
  output logic [DATA_WIDTH-1:0] alu_src_b
);

  logic [DATA_WIDTH:0] rs;
  logic                carry;
  logic                ge;

  always_comb begin
    // Shifted partial remainder; bit DATA_WIDTH means it already exceeds B.
    rs        = {hi, lo[DATA_WIDTH-1]};
    // The ALU has no carry out, so recover it from unsigned wrap-around.
    carry     = (alu_result < hi);
    ge        = rs[DATA_WIDTH] | (rs[DATA_WIDTH-1:0] >= opnd);
    hi_next   = hi;
    lo_next   = lo;
    alu_src_a = hi;
    alu_src_b = opnd;
    if (is_div) begin
      alu_src_a = rs[DATA_WIDTH-1:0];
      if (ge) begin
        // Difference is exact modulo 2^N even when rs overflowed N bits.
        hi_next = alu_result;
        lo_next = {lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rs[DATA_WIDTH-1:0];
        lo_next = {lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_next = {carry, alu_result[DATA_WIDTH-1:1]};
      lo_next = {alu_result[0], lo[DATA_WIDTH-1:1]};
    end else begin
      hi_next = {1'b0, hi[DATA_WIDTH-1:1]};
      lo_next = {hi[0], lo[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer : multi-cycle unsigned MUL/MULHU/DIVU/REMU controller that
// borrows the execute-stage ALU for one add/subtract per cycle, DATA_WIDTH
// iterations per operation, and raises Busy as a pipeline stall.
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus        : mdu_sequencer_if slave port (request, status, result and
//                shared-ALU signals).
// Optional build macro MDU_ZERO_SKIP_EN: multiplies with a zero operand
// finish immediately (IDLE -> DONE) with Result = 0.
// ---------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mdu_sequencer_if.slave bus
);
  import mdu_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  mdu_state_t            state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [1:0]            op_reg, op_next;
  logic [DATA_WIDTH-1:0] hi_reg, hi_next;
  logic [DATA_WIDTH-1:0] lo_reg, lo_next;
  logic [DATA_WIDTH-1:0] opnd_reg, opnd_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;

  logic [DATA_WIDTH-1:0] step_hi, step_lo, step_a, step_b;
  logic                  running;

  mdu_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div     (op_is_div(op_reg)),
    .hi         (hi_reg),
    .lo         (lo_reg),
    .opnd       (opnd_reg),
    .alu_result (bus.ALUResult),
    .hi_next    (step_hi),
    .lo_next    (step_lo),
    .alu_src_a  (step_a),
    .alu_src_b  (step_b)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    op_next     = op_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    opnd_next   = opnd_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        // Flush in IDLE swallows a simultaneous Start.
        if (bus.Start && !bus.Flush) begin
          op_next    = bus.Op;
          count_next = '0;
          hi_next    = '0;
          if (op_is_div(bus.Op) && (bus.OpB == '0)) begin
            // Divide by zero: DIVU -> all ones, REMU -> dividend.
            state_next  = DONE;
            result_next = bus.Op[0] ? bus.OpA : '1;
`ifdef MDU_ZERO_SKIP_EN
          end else if (!op_is_div(bus.Op) &&
                       ((bus.OpA == '0) || (bus.OpB == '0))) begin
            state_next  = DONE;
            result_next = '0;
`endif
          end else begin
            state_next = RUN;
            // Multiply shifts the multiplier through Lo; divide shifts the
            // dividend through Q. The other operand stays put.
            lo_next    = op_is_div(bus.Op) ? bus.OpA : bus.OpB;
            opnd_next  = op_is_div(bus.Op) ? bus.OpB : bus.OpA;
          end
        end
      end
      RUN: begin
        if (bus.Flush) begin
          state_next = IDLE;
        end else begin
          hi_next    = step_hi;
          lo_next    = step_lo;
          count_next = count_reg + 1'b1;
          if (count_reg == LAST_ITER) begin
            state_next  = DONE;
            // MULHU/REMU take the upper register, MUL/DIVU the lower.
            result_next = op_reg[0] ? step_hi : step_lo;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      op_reg     <= op_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      opnd_reg   <= opnd_next;
      result_reg <= result_next;
    end
  end

  assign running        = (state_reg == RUN);
  assign bus.Busy       = (state_reg != IDLE);
  assign bus.Done       = (state_reg == DONE);
  assign bus.Result     = result_reg;
  assign bus.ALUReq     = running;
  assign bus.ALUControl = (running && op_is_div(op_reg)) ?
                          CONTROL_WIDTH'(ALU_SUB) : CONTROL_WIDTH'(ALU_ADD);
  assign bus.ALUSrcA    = running ? step_a : '0;
  assign bus.ALUSrcB    = running ? step_b : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer : directed bench for mdu_sequencer with a scoreboard queue
// of expected results and a behavioural model of the shared execute ALU.
// ---------------------------------------------------------------------------
module tb_mdu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.DATA_WIDTH(32), .CONTROL_WIDTH(3)) bus ();

  mdu_sequencer #(.DATA_WIDTH(32), .CONTROL_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Execute-stage ALU: 000 = add, anything else used here = subtract.
  always_comb begin
    bus.ALUResult = (bus.ALUControl == 3'b000) ? (bus.ALUSrcA + bus.ALUSrcB)
                                               : (bus.ALUSrcA - bus.ALUSrcB);
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'h0;

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents Start for one cycle; returns 1 time unit after edge E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    @(posedge clk); #1;
    bus.Start = 1'b1; bus.Op = op; bus.OpA = a; bus.OpB = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  // Waits for Done; edge index k means Done is seen in the cycle after Ek.
  task automatic wait_done(input string tag, input int edge_offs,
                           input int exp_edge, input int exp_req,
                           input logic [2:0] exp_ctl, input bit start_in_done);
    int req_cnt = 0;
    int ctl_bad = 0;
    int k = -1;
    bit seen = 1'b0;
    logic [31:0] exp;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (bus.ALUReq) begin
        req_cnt++;
        if (bus.ALUControl !== exp_ctl) ctl_bad++;
      end
      if (bus.Done) begin
        seen = 1'b1;
        k = n + edge_offs;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'h1);
    if (seen) begin
      check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 32'h1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
      check({tag, "_result"}, bus.Result, exp);
      check({tag, "_done_edge"}, 32'(k), 32'(exp_edge));
      check({tag, "_alureq_cycles"}, 32'(req_cnt), 32'(exp_req));
      check({tag, "_alucontrol_bad"}, 32'(ctl_bad), 32'h0);
      last_result = exp;
      if (start_in_done) begin
        bus.Start = 1'b1; bus.Op = 2'b00; bus.OpA = 32'd1; bus.OpB = 32'd1;
      end
      @(negedge clk);
      bus.Start = 1'b0;
      check({tag, "_done_pulse"}, 32'(bus.Done), 32'h0);
      check({tag, "_idle_after"}, 32'(bus.Busy), 32'h0);
      check({tag, "_result_held"}, bus.Result, last_result);
    end
  endtask

  // Counts Done pulses over a window in which none may appear.
  task automatic expect_no_done(input string tag, input int cycles);
    int dones = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check({tag, "_no_done"}, 32'(dones), 32'h0);
    check({tag, "_result_kept"}, bus.Result, last_result);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(bus.Busy), 32'h0);
    check({tag, "_done"},    32'(bus.Done), 32'h0);
    check({tag, "_result"},  bus.Result, 32'h0);
    check({tag, "_alureq"},  32'(bus.ALUReq), 32'h0);
    check({tag, "_aluctl"},  32'(bus.ALUControl), 32'h0);
    check({tag, "_srca"},    bus.ALUSrcA, 32'h0);
    check({tag, "_srcb"},    bus.ALUSrcB, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0; bus.Op = 2'b00; bus.OpA = 32'h0; bus.OpB = 32'h0;
    bus.Flush = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(2'b00, 32'd7, 32'd6, 1'b1);
    wait_done("mul_7x6", 0, 32, 32, 3'b000, 1'b0);
    $display("MUL 7 x 6 -> 0x%08h", bus.Result);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mulhu_max", 0, 32, 32, 3'b000, 1'b0);
    $display("MULHU max x max -> 0x%08h", bus.Result);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("mul_max", 0, 32, 32, 3'b000, 1'b0);
    $display("MUL max x max -> 0x%08h", bus.Result);

    issue(2'b10, 32'd100, 32'd7, 1'b1);
    wait_done("divu_100_7", 0, 32, 32, 3'b001, 1'b0);
    $display("DIVU 100 / 7 -> 0x%08h", bus.Result);
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    wait_done("remu_100_7", 0, 32, 32, 3'b001, 1'b0);
    $display("REMU 100 / 7 -> 0x%08h", bus.Result);
    issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    wait_done("divu_rs32", 0, 32, 32, 3'b001, 1'b0);
    $display("DIVU 0xFFFFFFFF / 0x80000001 -> 0x%08h", bus.Result);
    issue(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    wait_done("remu_rs32", 0, 32, 32, 3'b001, 1'b1);
    $display("REMU 0xFFFFFFFF / 0x80000001 -> 0x%08h (Start in DONE)", bus.Result);

    issue(2'b10, 32'h1234, 32'h0, 1'b1);
    wait_done("divu_by0", 0, 0, 0, 3'b001, 1'b0);
    $display("DIVU 0x1234 / 0 -> 0x%08h", bus.Result);
    issue(2'b11, 32'h1234, 32'h0, 1'b1);
    wait_done("remu_by0", 0, 0, 0, 3'b001, 1'b0);
    $display("REMU 0x1234 / 0 -> 0x%08h", bus.Result);

    // Flush a multiply after ten iterations.
    issue(2'b00, 32'd3, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.Flush = 1'b1;
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.Busy), 32'h0);
    expect_no_done("flush", 40);
    $display("MUL flushed at iteration 10 -> Result 0x%08h", bus.Result);

    // Flush together with Start in IDLE: the request is dropped.
    @(posedge clk); #1;
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = 2'b00; bus.OpA = 32'd2; bus.OpB = 32'd2;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 32'(bus.Busy), 32'h0);
    $display("Start+Flush in IDLE -> Busy %0d", bus.Busy);

    // DIVU 9/2 with a stray Start during RUN.
    issue(2'b10, 32'd9, 32'd2, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.Start = 1'b1; bus.Op = 2'b00; bus.OpA = 32'd3; bus.OpB = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    wait_done("divu_9_2", 6, 32, 26, 3'b001, 1'b0);
    $display("DIVU 9 / 2 with Start in RUN -> 0x%08h", bus.Result);

    // Asynchronous reset in the middle of a multiply.
    issue(2'b00, 32'd7, 32'd6, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_result = 32'h0;
    expect_no_done("after_reset", 40);
    $display("Reset mid-RUN -> Busy %0d Result 0x%08h", bus.Busy, bus.Result);

    issue(2'b00, 32'd0, 32'd5, 1'b1);
`ifdef MDU_ZERO_SKIP_EN
    wait_done("mul_0x5", 0, 0, 0, 3'b000, 1'b0);
`else
    wait_done("mul_0x5", 0, 32, 32, 3'b000, 1'b0);
`endif
    $display("MUL 0 x 5 -> 0x%08h", bus.Result);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
